// File: rtl/cobro_cafe.sv
// Coffee vending controller: takes an order, collects coins, dispenses for a fixed time, then pays back change.
// Optional macro COBRO_CAFE_CAMBIO_EN enables returning excess credit as change after a dispense.
module cobro_cafe #(
  parameter int ESPERA_DISPENSA = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] tipoCafe,
  input  logic [5:0] costo,
  input  logic       pedir,
  input  logic [1:0] moneda,
  input  logic       cancelar,
  output logic [5:0] credito,
  output logic       dispensar,
  output logic [1:0] cafeSalida,
  output logic [5:0] cambio,
  output logic       cambioValido,
  output logic       ocupado,
  output logic       monedaRechazada
);

  typedef enum logic [1:0] {IDLE, COBRO, DISPENSA, CAMBIO} state_t;

  localparam logic [7:0] CNT_INIT = 8'(ESPERA_DISPENSA - 1);

  state_t     state_q, state_d;
  logic [5:0] credito_q, credito_d;
  logic [5:0] costo_q, costo_d;
  logic [1:0] tipo_q, tipo_d;
  logic [7:0] cnt_q, cnt_d;
  logic       refund_q, refund_d;
  logic       rech_q, rech_d;

  logic [6:0] coin_val;
  logic [6:0] sum;
  logic [5:0] credito_sat;

  always_comb begin
    coin_val = 7'd0;
    case (moneda)
      2'b01:   coin_val = 7'd1;
      2'b10:   coin_val = 7'd2;
      2'b11:   coin_val = 7'd5;
      default: coin_val = 7'd0;
    endcase
  end

  // Credit saturates at 63 rather than wrapping.
  assign sum         = {1'b0, credito_q} + coin_val;
  assign credito_sat = (sum > 7'd63) ? 6'd63 : sum[5:0];

  always_comb begin
    state_d   = state_q;
    credito_d = credito_q;
    costo_d   = costo_q;
    tipo_d    = tipo_q;
    cnt_d     = cnt_q;
    refund_d  = refund_q;
    rech_d    = (moneda != 2'b00) && (state_q != COBRO);
    case (state_q)
      IDLE: begin
        if (pedir) begin
          tipo_d   = tipoCafe;
          costo_d  = costo;
          refund_d = 1'b0;
          state_d  = COBRO;
        end
      end
      COBRO: begin
        credito_d = credito_sat;
        if (cancelar) begin
          refund_d = 1'b1;
          state_d  = CAMBIO;
        end else if (credito_sat >= costo_q) begin
          cnt_d   = CNT_INIT;
          state_d = DISPENSA;
        end
      end
      DISPENSA: begin
        if (cnt_q == 8'd0) begin
          state_d = CAMBIO;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      CAMBIO: begin
        credito_d = 6'd0;
        refund_d  = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      credito_q <= 6'd0;
      costo_q   <= 6'd0;
      tipo_q    <= 2'b00;
      cnt_q     <= 8'd0;
      refund_q  <= 1'b0;
      rech_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      credito_q <= credito_d;
      costo_q   <= costo_d;
      tipo_q    <= tipo_d;
      cnt_q     <= cnt_d;
      refund_q  <= refund_d;
      rech_q    <= rech_d;
    end
  end

  assign credito         = credito_q;
  assign dispensar       = (state_q == DISPENSA);
  assign cafeSalida      = dispensar ? tipo_q : 2'b00;
  assign ocupado         = (state_q != IDLE);
  assign monedaRechazada = rech_q;

`ifdef COBRO_CAFE_CAMBIO_EN
  assign cambioValido = (state_q == CAMBIO);
  assign cambio       = !cambioValido ? 6'd0 :
                        refund_q      ? credito_q : (credito_q - costo_q);
`else
  // Without change support only a cancelled order pays anything back, and even then no amount is reported.
  assign cambioValido = (state_q == CAMBIO) && refund_q;
  assign cambio       = 6'd0;
`endif

endmodule

// File: doc/cobro_cafe.md
COBRO_CAFE -- requirements
Module: cobro_cafe

Interface
REQ-001 SHALL have parameter ESPERA_DISPENSA, default 4, number of cycles dispensar is held high (legal 1..255).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port tipoCafe  input  2  coffee code: 00 expreso, 01 con leche, 10 capuccino, 11 mocaccino.
REQ-005 SHALL have port costo  input  6  price of tipoCafe, driven combinationally by the cost-lookup stage.
REQ-006 SHALL have port pedir  input  1  order request, sampled only in IDLE.
REQ-007 SHALL have port moneda  input  2  coin this cycle: 00 none, 01 = 1, 10 = 2, 11 = 5.
REQ-008 SHALL have port cancelar  input  1  abort order and refund, sampled only in COBRO.
REQ-009 SHALL have port credito  output  6  accumulated credit.
REQ-010 SHALL have port dispensar  output  1  dispense strobe.
REQ-011 SHALL have port cafeSalida  output  2  latched coffee code, valid while dispensar=1, else 00.
REQ-012 SHALL have port cambio  output  6  change amount, valid only while cambioValido=1, else 0.
REQ-013 SHALL have port cambioValido  output  1  one-cycle change strobe.
REQ-014 SHALL have port ocupado  output  1  high in every state except IDLE.
REQ-015 SHALL have port monedaRechazada  output  1  registered pulse, one cycle after a nonzero moneda arrives outside COBRO.

Function
REQ-016 SHALL implement FSM states IDLE, COBRO, DISPENSA, CAMBIO.
REQ-017 IDLE: pedir=1 SHALL latch tipoCafe and costo into internal registers and enter COBRO next cycle; tipoCafe/costo changes afterwards SHALL be ignored.
REQ-018 COBRO: each cycle credito_next = min(credito + coin value, 63); saturate, never wrap.
REQ-019 COBRO: if credito_next >= latched costo and cancelar=0, SHALL enter DISPENSA next cycle.
REQ-020 COBRO: cancelar=1 SHALL enter CAMBIO in refund mode; a same-cycle coin is counted and refunded; cancel wins over sufficient credit.
REQ-021 A latched costo of 0 SHALL go COBRO -> DISPENSA after one cycle without a coin.
REQ-022 DISPENSA: dispensar=1 and cafeSalida=latched code for exactly ESPERA_DISPENSA cycles, counted by an internal down-counter, then enter CAMBIO.
REQ-023 CAMBIO: lasts one cycle; cambioValido=1; cambio = credito - costo after dispense, or credito in refund mode; credito cleared to 0 on exit; next state IDLE.
REQ-024 pedir outside IDLE and cancelar outside COBRO SHALL be ignored.
REQ-025 All outputs SHALL be registered or decoded from state only; no combinational input-to-output path.

Reset
REQ-026 rst=1 SHALL force IDLE, credito=0, dispensar=0, cafeSalida=00, cambio=0, cambioValido=0, ocupado=0, monedaRechazada=0, counter=0, latched registers=0 on the next edge.
REQ-027 rst mid-operation SHALL discard credit without emitting cambioValido and end dispensar on the following edge; rst overrides all inputs in the same cycle.

Configuration
REQ-028 Macro COBRO_CAFE_CAMBIO_EN defined: CAMBIO behaves per REQ-023.
REQ-029 Macro COBRO_CAFE_CAMBIO_EN undefined: cambio tied to 0; cambioValido asserts only in refund mode (cambio still 0); excess credit is discarded. CAMBIO still lasts one cycle, credito is still cleared, ocupado timing is unchanged.

Verification
REQ-030 tipoCafe=00, costo=3, pedir; moneda 10, 10 -> credito 2, 4; dispensar high 4 cycles with cafeSalida=00; then cambioValido with cambio=1; credito=0; IDLE.
REQ-031 tipoCafe=11, costo=7, pedir; moneda 11, then cancelar with moneda 01 -> no dispensar; cambioValido with cambio=6.
REQ-032 costo=63, 13 consecutive moneda 11 -> credito saturates at 63; dispensar; cambio=0.
REQ-033 rst asserted in 2nd DISPENSA cycle -> dispensar=0, credito=0, ocupado=0 next cycle; no cambioValido.
REQ-034 moneda 01 during DISPENSA -> credito unchanged; monedaRechazada high for one cycle; pedir during COBRO ignored.
REQ-035 Macro undefined, run the REQ-030 stimulus -> dispensar as before; cambioValido stays 0; cambio stays 0.
